soc_event_queue: RTL and testbench



---
 rtl/soc_evt_pkg.sv | 11 +
 rtl/soc_evt_rr_arb.sv | 43 ++++
 rtl/soc_event_queue.sv | 117 +++++++++++
 tb/tb_soc_event_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_evt_pkg.sv
// soc_evt_pkg: shared types, widths and index helper for the SoC event queue
package soc_evt_pkg;
    localparam int EVT_ID_WIDTH_DEF = 8;
    localparam int DROP_CNT_WIDTH   = 16;

    typedef logic [EVT_ID_WIDTH_DEF-1:0] evt_id_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/soc_evt_rr_arb.sv
// soc_evt_rr_arb: round-robin arbiter, search starts at the pointer and the
// pointer moves one past the winner on every grant
module soc_evt_rr_arb
    import soc_evt_pkg::*;
#(
    parameter int N = 32,
    localparam int W = idx_w(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_valid_o
);
    logic [W-1:0] ptr_q, ptr_d;
    logic [W:0]   sum;
    logic [W-1:0] k;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        sum         = '0;
        k           = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (W+1)'(i);
            k   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
            if (!gnt_valid_o && en_i && req_i[k]) begin
                gnt_valid_o = 1'b1;
                gnt_o[k]    = 1'b1;
                gnt_idx_o   = k;
            end
        end
        ptr_d = gnt_valid_o ? ((gnt_idx_o == W'(N-1)) ? '0 : gnt_idx_o + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/soc_event_queue.sv
// soc_event_queue: per-source pending counters, round-robin arbitration and an
// output ID FIFO feeding the FC event FIFO. SOC_EVT_DROP_CNT_EN adds drop_cnt_o.
module soc_event_queue
    import soc_evt_pkg::*;
#(
    parameter int NB_SOURCES     = 32,
    parameter int EVENT_ID_WIDTH = EVT_ID_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int PEND_CNT_WIDTH = 2,
    parameter int ID_BASE        = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_SOURCES-1:0]     evt_i,
    output logic                      evt_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
    input  logic                      evt_fulln_i,
    output logic                      overflow_o,
    input  logic                      overflow_clr_i,
`ifdef SOC_EVT_DROP_CNT_EN
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
`endif
    output logic [NB_SOURCES-1:0]     pending_o
);
    localparam int AW = idx_w(FIFO_DEPTH);
    localparam int SW = idx_w(NB_SOURCES);
    localparam logic [PEND_CNT_WIDTH-1:0] CNT_MAX = '1;

    if (ID_BASE + NB_SOURCES > 2**EVENT_ID_WIDTH) begin : g_id_range_chk
        $error("soc_event_queue: ID_BASE+NB_SOURCES exceeds the event ID space");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("soc_event_queue: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [PEND_CNT_WIDTH-1:0] cnt_q [NB_SOURCES];
    logic [PEND_CNT_WIDTH-1:0] cnt_d [NB_SOURCES];
    logic [NB_SOURCES-1:0]     gnt, drop;
    logic [SW-1:0]             gnt_idx;
    logic                      gnt_valid;
    logic [EVENT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_q, rd_q;
    logic [AW:0]               occ_q, occ_d;
    logic                      push, pop, ovf_q, ovf_d;

    // Grant only with a free slot now; a same-cycle pop does not count as space.
    soc_evt_rr_arb #(.N(NB_SOURCES)) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (pending_o),
        .en_i        (occ_q != (AW+1)'(FIFO_DEPTH)),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign push        = gnt_valid;
    assign pop         = evt_valid_o && evt_fulln_i;
    assign evt_valid_o = occ_q != '0;
    assign evt_data_o  = mem_q[rd_q];
    assign overflow_o  = ovf_q;

    always_comb begin
        pending_o = '0;
        drop      = '0;
        for (int i = 0; i < NB_SOURCES; i++) begin
            pending_o[i] = cnt_q[i] != '0;
            drop[i]      = evt_i[i] && !gnt[i] && (cnt_q[i] == CNT_MAX);
            cnt_d[i]     = (evt_i[i] && !gnt[i] && !drop[i]) ? cnt_q[i] + 1'b1 :
                           (gnt[i] && !evt_i[i])             ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
        occ_d = (push && !pop) ? occ_q + 1'b1 : (pop && !push) ? occ_q - 1'b1 : occ_q;
        ovf_d = (|drop) ? 1'b1 : overflow_clr_i ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_SOURCES; i++) cnt_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NB_SOURCES; i++) cnt_q[i] <= cnt_d[i];
            if (push) begin
                mem_q[wr_q] <= EVENT_ID_WIDTH'(ID_BASE) + EVENT_ID_WIDTH'(gnt_idx);
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef SOC_EVT_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_WIDTH:0]   drop_sum;
    logic [SW:0]               n_drop;

    // Saturating add of this cycle's drop popcount; an increment beats a clear.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NB_SOURCES; i++) n_drop = n_drop + (SW+1)'(drop[i]);
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_WIDTH+1)'(n_drop);
        drop_cnt_d = (n_drop != '0) ? (drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0]) :
                     overflow_clr_i ? '0 : drop_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_soc_event_queue.sv
// tb_soc_event_queue: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the event queue.
module tb_soc_event_queue;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] evt_i;
    logic        evt_valid_o;
    logic [7:0]  evt_data_o;
    logic        evt_fulln_i;
    logic        overflow_o;
    logic        overflow_clr_i;
    logic [31:0] pending_o;

    soc_event_queue dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .evt_i          (evt_i),
        .evt_valid_o    (evt_valid_o),
        .evt_data_o     (evt_data_o),
        .evt_fulln_i    (evt_fulln_i),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .pending_o      (pending_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int m_cnt [32];
    int m_ptr;
    int m_q [$];
    bit m_ovf;
    int pops_of [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_ptr = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic clear_pops();
        for (int i = 0; i < 256; i++) pops_of[i] = 0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        for (int i = 0; i < 32; i++) p[i] = m_cnt[i] != 0;
        return p;
    endfunction

    task automatic check_model();
        chk("valid", 32'(evt_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data", 32'(evt_data_o), 32'(m_q[0]));
        chk("pending", pending_o, model_pending());
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic cycle(input logic [31:0] e, input logic f, input logic c);
        int g;
        int k;
        bit dropped;
        evt_i = e;
        evt_fulln_i = f;
        overflow_clr_i = c;
        if (evt_valid_o && f) pops_of[evt_data_o]++;
        g = -1;
        if (m_q.size() < 4) begin
            for (int i = 0; i < 32; i++) begin
                k = (m_ptr + i) % 32;
                if (g < 0 && m_cnt[k] > 0) g = k;
            end
        end
        dropped = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (e[i] && g != i) begin
                if (m_cnt[i] == 3) dropped = 1'b1;
                else m_cnt[i]++;
            end else if (!e[i] && g == i) m_cnt[i]--;
        end
        m_ovf = dropped ? 1'b1 : c ? 1'b0 : m_ovf;
        if (m_q.size() > 0 && f) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_ptr = (g + 1) % 32;
        end
        @(posedge clk_i);
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] e;
        rst_ni = 1'b0;
        evt_i = '0;
        evt_fulln_i = 1'b1;
        overflow_clr_i = 1'b0;
        model_reset();
        clear_pops();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("rst_valid", 32'(evt_valid_o), 0);
        chk("rst_data", 32'(evt_data_o), 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_overflow", 32'(overflow_o), 0);

        // single event, latency N+2
        cycle(32'h20, 1, 0);
        chk("single_pend", pending_o, 32'h20);
        chk("single_valid_n1", 32'(evt_valid_o), 0);
        cycle(0, 1, 0);
        chk("single_valid_n2", 32'(evt_valid_o), 1);
        chk("single_data", 32'(evt_data_o), 5);
        cycle(0, 1, 0);
        chk("single_valid_n3", 32'(evt_valid_o), 0);

        // round-robin with pointer at 6: 31, 0, 3
        e = 32'h8000_0009;
        cycle(e, 1, 0);
        cycle(0, 1, 0); chk("rr6_a", 32'(evt_data_o), 31);
        cycle(0, 1, 0); chk("rr6_b", 32'(evt_data_o), 0);
        cycle(0, 1, 0); chk("rr6_c", 32'(evt_data_o), 3);
        cycle(0, 1, 0); chk("rr6_empty", 32'(evt_valid_o), 0);
        // bring pointer to 0, then expect 0, 3, 31
        cycle(32'h8000_0000, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(e, 1, 0);
        cycle(0, 1, 0); chk("rr0_a", 32'(evt_data_o), 0);
        cycle(0, 1, 0); chk("rr0_b", 32'(evt_data_o), 3);
        cycle(0, 1, 0); chk("rr0_c", 32'(evt_data_o), 31);
        cycle(0, 1, 0); chk("rr0_empty", 32'(evt_valid_o), 0);

        // backpressure: 6 sources, 4 slots
        clear_pops();
        cycle(32'h0010_0706, 0, 0);
        repeat (6) cycle(0, 0, 0);
        chk("bp_valid", 32'(evt_valid_o), 1);
        chk("bp_head", 32'(evt_data_o), 1);
        chk("bp_pending", pending_o, 32'h0010_0400);
        repeat (10) cycle(0, 1, 0);
        chk("bp_delivered", 32'(pops_of[1] + pops_of[2] + pops_of[8] + pops_of[9] + pops_of[10] + pops_of[20]), 6);
        chk("bp_drained", 32'(evt_valid_o), 0);

        // saturation of source 2 behind a full FIFO
        clear_pops();
        cycle(32'h0000_7800, 0, 0);
        repeat (5) cycle(0, 0, 0);
        chk("sat_head", 32'(evt_data_o), 11);
        repeat (3) cycle(32'h4, 0, 0);
        chk("sat_no_ovf", 32'(overflow_o), 0);
        cycle(32'h4, 0, 0);
        chk("sat_ovf", 32'(overflow_o), 1);
        cycle(32'h4, 0, 1);
        chk("sat_set_beats_clr", 32'(overflow_o), 1);
        cycle(0, 0, 1);
        chk("sat_clr", 32'(overflow_o), 0);
        repeat (12) cycle(0, 1, 0);
        chk("sat_id2_count", 32'(pops_of[2]), 3);

        // simultaneous increment and decrement on source 7
        clear_pops();
        cycle(32'h80, 1, 0);
        cycle(32'h80, 1, 0);
        chk("incdec_pending", pending_o, 32'h80);
        chk("incdec_data", 32'(evt_data_o), 7);
        repeat (4) cycle(0, 1, 0);
        chk("incdec_id7_count", 32'(pops_of[7]), 2);

        // reset mid-operation with 3 queued IDs and one pending source
        cycle(32'h70, 0, 0);
        repeat (3) cycle(0, 0, 0);
        cycle(32'h200, 0, 0);
        chk("mid_pending", pending_o, 32'h200);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid_o), 0);
        chk("mid_rst_pending", pending_o, 0);
        chk("mid_rst_data", 32'(evt_data_o), 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) cycle(0, 1, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            e = ($urandom_range(1) == 0) ? 32'h0 : ($urandom & $urandom & $urandom & $urandom);
            cycle(e, $urandom_range(3) != 0, $urandom_range(19) == 0);
        end
        repeat (80) cycle(0, 1, 1);
        chk("final_idle", 32'(evt_valid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
